quant_4x4_seq: RTL and testbench
================================

QUANT_4X4_SEQ -- requirements
Module: quant_4x4_seq

Interface
- REQ-001: Parameter BIT_LENGTH, default 15; every coefficient and level is BIT_LENGTH+1 bits wide, two's complement.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: enable  input  1  clock enable; when low, all state, outputs and the pipeline hold.
- REQ-005: in_valid  input  1  a block of coefficients is presented.
- REQ-006: in_ready  output  1  block can be accepted.
- REQ-007: coeff  input  [BIT_LENGTH:0] x16  forward-transformed 4x4 block, raster order (index = 4*row + col).
- REQ-008: QP_BY_6  input  4  QP/6, legal range 0..8.
- REQ-009: QP_MOD_6  input  3  QP%6, legal range 0..5.
- REQ-010: intra  input  1  rounding mode: 1 = intra, 0 = inter.
- REQ-011: out_valid  output  1  quantized block is available.
- REQ-012: out_ready  input  1  consumer accepts the block.
- REQ-013: quantized  output  [BIT_LENGTH:0] x16  quantized levels, raster order.

Function
- REQ-014: A block is accepted on a rising edge where enable, in_valid and in_ready are all high; coeff, QP_BY_6, QP_MOD_6 and intra are captured on that edge, and later input changes have no effect on the block.
- REQ-015: States are IDLE, RUN and DONE; in_ready is high only in IDLE, and out_valid is high only in DONE.
- REQ-016: IDLE->RUN on accept; RUN->DONE when the final level is written; DONE->IDLE on an edge where enable and out_ready are high.
- REQ-017: In RUN, coefficient index k (0..15) issues on the k-th enabled cycle after accept, one per cycle, into a 2-stage pipeline.
- REQ-018: Stage 1 computes |W| as 17-bit unsigned, selects MF and forms |W|*MF in at least 31 bits.
- REQ-019: Stage 2 computes ((|W|*MF + f) >> qbits), restores the sign of W and writes quantized[k].
- REQ-020: qbits = 15 + QP_BY_6.
- REQ-021: f = floor(2^qbits/3) when intra is 1, and floor(2^qbits/6) when intra is 0.
- REQ-022: MF for positions {0,2,8,10} by QP_MOD_6 0..5 = 13107, 11916, 10082, 9362, 8192, 7282.
- REQ-023: MF for positions {5,7,13,15} by QP_MOD_6 0..5 = 5243, 4660, 4194, 3647, 3355, 2893.
- REQ-024: MF for all other positions by QP_MOD_6 0..5 = 8066, 7490, 6554, 5825, 5243, 4559.
- REQ-025: A zero magnitude result is output as 0, never as negative zero.
- REQ-026: With enable held high, out_valid rises exactly 18 clock edges after the accepting edge.
- REQ-027: Block throughput is one block per 19 cycles minimum; accept and output never overlap.
- REQ-028: quantized holds its value from DONE until the next block's first write; entries not yet written keep their previous values.
- REQ-029: QP_BY_6 values 9..15 are treated as 8, and QP_MOD_6 values 6..7 are treated as 0.
- REQ-030: If enable is low mid-RUN, the pipeline freezes with no lost or duplicated coefficient, and latency extends by the number of low cycles.

Reset
- REQ-031: Asserting reset forces IDLE, in_ready=1, out_valid=0, quantized=0 for all 16 entries, index=0 and pipeline valid bits=0, independent of clk and enable.
- REQ-032: Reset asserted mid-RUN or in DONE discards the block; no partial out_valid appears after release.
- REQ-033: The first accept is possible on the first enabled edge after reset deassertion.

Configuration
- REQ-034: The macro QUANT4X4_NZ_COUNT_EN, when defined, adds output nz_count [4:0].
- REQ-035: nz_count gives the number of nonzero levels in the block. It is valid with out_valid, resets to 0 and is cleared on accept.
- REQ-036: When QUANT4X4_NZ_COUNT_EN is undefined, the port and its logic are absent, and all other behaviour is identical.

Verification
- REQ-037: QP=28 (QP_BY_6=4, QP_MOD_6=4), intra=1, coeff[0]=100, coeff[1]=-100, others 0 -> quantized[0]=1, quantized[1]=-1, others 0; out_valid 18 edges after accept; nz_count=2 when enabled.
- REQ-038: QP=28, coeff[0]=50: intra=1 -> quantized[0]=1; intra=0 -> quantized[0]=0.
- REQ-039: QP=0, intra=1, coeff[0]=-32768, coeff[5]=1000, coeff[1]=1000 -> quantized[0]=-13107, quantized[5]=160, quantized[1]=246.
- REQ-040: out_ready held low 10 cycles after out_valid -> out_valid and quantized stable, in_ready low; a new in_valid is ignored until DONE->IDLE.
- REQ-041: enable toggled low for 3 cycles at index 7 -> identical results, out_valid at edge 21.
- REQ-042: reset pulsed low at index 9 -> out_valid stays 0, quantized=0, in_ready=1; the next block completes normally.

Source files
------------

// File: rtl/quant_4x4_seq_if.sv
// Block handshake and data bus for the 4x4 quantizer.
// QUANT4X4_NZ_COUNT_EN adds the nz_count field carrying the per-block nonzero-level count.
interface quant_4x4_seq_if #(
    parameter int BIT_LENGTH = 15
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIT_LENGTH:0]   coeff [16];
    logic [3:0]            QP_BY_6;
    logic [2:0]            QP_MOD_6;
    logic                  intra;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIT_LENGTH:0]   quantized [16];
`ifdef QUANT4X4_NZ_COUNT_EN
    logic [4:0]            nz_count;

    modport master (
        output in_valid, coeff, QP_BY_6, QP_MOD_6, intra, out_ready,
        input  in_ready, out_valid, quantized, nz_count
    );
    modport slave (
        input  in_valid, coeff, QP_BY_6, QP_MOD_6, intra, out_ready,
        output in_ready, out_valid, quantized, nz_count
    );
`else
    modport master (
        output in_valid, coeff, QP_BY_6, QP_MOD_6, intra, out_ready,
        input  in_ready, out_valid, quantized
    );
    modport slave (
        input  in_valid, coeff, QP_BY_6, QP_MOD_6, intra, out_ready,
        output in_ready, out_valid, quantized
    );
`endif
endinterface

// File: rtl/quant_4x4_seq.sv
// Sequential H.264-style 4x4 quantizer: one coefficient per enabled cycle through a
// two-stage datapath behind an issue register. Optional macro: QUANT4X4_NZ_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | issuing coefficients 0..15 and writing levels
// DONE  | block complete, out_valid high until out_ready
module quant_4x4_seq #(
    parameter int BIT_LENGTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    quant_4x4_seq_if.slave   bus
);
    localparam int CW = BIT_LENGTH + 1;
    localparam int MW = CW + 1;
    localparam int PW = MW + 14;
    localparam int SW = (PW + 1 > 32) ? PW + 1 : 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_nx;

    logic [CW-1:0] cap_coeff [16];
    logic [3:0]    cap_qpb;
    logic [2:0]    cap_qpm;
    logic          cap_intra;

    logic [4:0]    issue_cnt;
    logic          iss_v;
    logic [3:0]    iss_k;
    logic [CW-1:0] iss_w;

    logic          s1_v;
    logic [3:0]    s1_k;
    logic          s1_neg;
    logic [PW-1:0] s1_prod;

    logic [CW-1:0] quant_q [16];

    logic accept, issue, last_write;

    assign accept     = enable && bus.in_valid && (state_q == IDLE);
    assign issue      = enable && (state_q == RUN) && !issue_cnt[4];
    assign last_write = enable && s1_v && (s1_k == 4'd15);

    // Position class: even row & even col, odd row & odd col, or mixed.
    function automatic logic [13:0] mf_sel(input logic [3:0] k, input logic [2:0] m);
        logic [13:0] a, b, c;
        case (m)
            3'd1:    begin a = 14'd11916; b = 14'd4660; c = 14'd7490; end
            3'd2:    begin a = 14'd10082; b = 14'd4194; c = 14'd6554; end
            3'd3:    begin a = 14'd9362;  b = 14'd3647; c = 14'd5825; end
            3'd4:    begin a = 14'd8192;  b = 14'd3355; c = 14'd5243; end
            3'd5:    begin a = 14'd7282;  b = 14'd2893; c = 14'd4559; end
            default: begin a = 14'd13107; b = 14'd5243; c = 14'd8066; end
        endcase
        if (!k[0] && !k[2]) return a;
        if (k[0] && k[2])   return b;
        return c;
    endfunction

    logic [MW-1:0] w_ext, w_mag;
    logic [13:0]   mf;

    always_comb begin
        w_ext = {iss_w[CW-1], iss_w};
        w_mag = iss_w[CW-1] ? (~w_ext + MW'(1)) : w_ext;
        mf    = mf_sel(iss_k, cap_qpm);
    end

    logic [4:0]    qbits;
    logic [23:0]   f_intra;
    logic [SW-1:0] f_round, rnd_sum;
    logic [CW-1:0] lvl_mag, lvl;

    // floor(2^qbits/6) is exactly floor(2^qbits/3) halved.
    always_comb begin
        qbits = 5'd15 + {1'b0, cap_qpb};
        case (cap_qpb)
            4'd0:    f_intra = 24'd10922;
            4'd1:    f_intra = 24'd21845;
            4'd2:    f_intra = 24'd43690;
            4'd3:    f_intra = 24'd87381;
            4'd4:    f_intra = 24'd174762;
            4'd5:    f_intra = 24'd349525;
            4'd6:    f_intra = 24'd699050;
            4'd7:    f_intra = 24'd1398101;
            default: f_intra = 24'd2796202;
        endcase
        f_round = cap_intra ? SW'(f_intra) : SW'(f_intra >> 1);
        rnd_sum = SW'(s1_prod) + f_round;
        lvl_mag = CW'(rnd_sum >> qbits);
        lvl     = (s1_neg && (lvl_mag != '0)) ? (~lvl_mag + CW'(1)) : lvl_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                cap_coeff[i] <= '0;
                quant_q[i]   <= '0;
            end
            cap_qpb   <= '0;
            cap_qpm   <= '0;
            cap_intra <= 1'b0;
            issue_cnt <= '0;
            iss_v     <= 1'b0;
            iss_k     <= '0;
            iss_w     <= '0;
            s1_v      <= 1'b0;
            s1_k      <= '0;
            s1_neg    <= 1'b0;
            s1_prod   <= '0;
        end else if (enable) begin
            if (accept) begin
                cap_coeff <= bus.coeff;
                cap_qpb   <= (bus.QP_BY_6 > 4'd8) ? 4'd8 : bus.QP_BY_6;
                cap_qpm   <= (bus.QP_MOD_6 > 3'd5) ? 3'd0 : bus.QP_MOD_6;
                cap_intra <= bus.intra;
                issue_cnt <= '0;
            end
            if (issue) begin
                iss_w     <= cap_coeff[issue_cnt[3:0]];
                iss_k     <= issue_cnt[3:0];
                issue_cnt <= issue_cnt + 5'd1;
            end
            iss_v <= issue;
            s1_v  <= iss_v;
            if (iss_v) begin
                s1_prod <= PW'(w_mag) * PW'(mf);
                s1_neg  <= iss_w[CW-1];
                s1_k    <= iss_k;
            end
            if (s1_v) quant_q[s1_k] <= lvl;
        end
    end

`ifdef QUANT4X4_NZ_COUNT_EN
    logic [4:0] nz_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q <= '0;
        end else if (enable) begin
            if (accept)
                nz_q <= '0;
            else if (s1_v && (lvl != '0))
                nz_q <= nz_q + 5'd1;
        end
    end

    assign bus.nz_count = nz_q;
`endif

    assign bus.quantized = quant_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last_write) state_nx = DONE;
            DONE:    if (enable && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end
endmodule

// File: tb/tb_quant_4x4_seq.sv
// Self-checking bench for quant_4x4_seq: directed cases plus random blocks against
// an arithmetic reference of the quantization rule.
module tb_quant_4x4_seq;
    logic clk = 1'b0;
    logic reset;
    logic enable;

    quant_4x4_seq_if #(.BIT_LENGTH(15)) bus ();

    quant_4x4_seq #(.BIT_LENGTH(15)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int blk [16];
    int qpb, qpm;
    bit intra_b;

    function automatic int ref_level(int w, int k, int pb, int pm, bit in_intra);
        int mf_a [6] = '{13107, 11916, 10082, 9362, 8192, 7282};
        int mf_b [6] = '{5243, 4660, 4194, 3647, 3355, 2893};
        int mf_c [6] = '{8066, 7490, 6554, 5825, 5243, 4559};
        int row, col, qb, qm, qbits, mf;
        longint pow2, f, mag;
        qb = (pb > 8) ? 8 : pb;
        qm = (pm > 5) ? 0 : pm;
        qbits = 15 + qb;
        row = k / 4;
        col = k % 4;
        if ((row % 2 == 0) && (col % 2 == 0))      mf = mf_a[qm];
        else if ((row % 2 == 1) && (col % 2 == 1)) mf = mf_b[qm];
        else                                        mf = mf_c[qm];
        pow2 = longint'(1) << qbits;
        f = in_intra ? pow2 / 3 : pow2 / 6;
        mag = ((w < 0 ? -longint'(w) : longint'(w)) * mf + f) / pow2;
        return (w < 0) ? -int'(mag) : int'(mag);
    endfunction

    function automatic int rnd_coeff();
        logic signed [15:0] t;
        t = 16'($urandom);
        if ($urandom_range(0, 3) == 0) return 0;
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 4000)) - 2000;
        return int'(t);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        for (int i = 0; i < 16; i++) bus.coeff[i] = 16'(blk[i]);
        bus.QP_BY_6  = 4'(qpb);
        bus.QP_MOD_6 = 3'(qpm);
        bus.intra    = intra_b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) bus.coeff[i] = 16'($urandom);
        bus.QP_BY_6  = 4'($urandom);
        bus.QP_MOD_6 = 3'($urandom);
        bus.intra    = ~intra_b;
    endtask

    task automatic wait_done(input string tag, input int start_n, input int exp_lat);
        int n;
        n = start_n;
        while (!bus.out_valid && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic check_levels(input string tag);
        int nz;
        int e;
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            e = ref_level(blk[i], i, qpb, qpm, intra_b);
            if (e != 0) nz++;
            chk($sformatf("%s_q%0d", tag, i), int'($signed(bus.quantized[i])), e);
        end
`ifdef QUANT4X4_NZ_COUNT_EN
        chk({tag, "_nz_count"}, int'(bus.nz_count), nz);
`endif
    endtask

    task automatic finish_block(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_back_idle"}, int'(bus.in_ready), 1);
        chk({tag, "_valid_low"}, int'(bus.out_valid), 0);
    endtask

    task automatic set_zero_block();
        for (int i = 0; i < 16; i++) blk[i] = 0;
    endtask

    task automatic set_random_block();
        for (int i = 0; i < 16; i++) blk[i] = rnd_coeff();
        qpb = int'($urandom_range(0, 15));
        qpm = int'($urandom_range(0, 7));
        intra_b = 1'($urandom_range(0, 1));
    endtask

    int nzq;

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.QP_BY_6 = '0;
        bus.QP_MOD_6 = '0;
        bus.intra = 1'b0;
        for (int i = 0; i < 16; i++) bus.coeff[i] = '0;
        repeat (3) tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        nzq = 0;
        for (int i = 0; i < 16; i++) if (bus.quantized[i] != '0) nzq++;
        chk("rst_quant_zero", nzq, 0);
        reset = 1'b1;

        // QP 28, intra, +/-100
        set_zero_block();
        blk[0] = 100; blk[1] = -100;
        qpb = 4; qpm = 4; intra_b = 1'b1;
        start_block("qp28");
        wait_done("qp28", 0, 18);
        chk("qp28_q0_direct", int'($signed(bus.quantized[0])), 1);
        chk("qp28_q1_direct", int'($signed(bus.quantized[1])), -1);
        check_levels("qp28");
        finish_block("qp28");

        // Rounding offset: intra vs inter
        set_zero_block();
        blk[0] = 50; qpb = 4; qpm = 4; intra_b = 1'b1;
        start_block("r_intra");
        wait_done("r_intra", 0, 18);
        chk("r_intra_q0", int'($signed(bus.quantized[0])), 1);
        finish_block("r_intra");
        intra_b = 1'b0;
        start_block("r_inter");
        wait_done("r_inter", 0, 18);
        chk("r_inter_q0", int'($signed(bus.quantized[0])), 0);
        finish_block("r_inter");

        // QP 0 extremes
        set_zero_block();
        blk[0] = -32768; blk[5] = 1000; blk[1] = 1000;
        qpb = 0; qpm = 0; intra_b = 1'b1;
        start_block("qp0");
        wait_done("qp0", 0, 18);
        chk("qp0_q0", int'($signed(bus.quantized[0])), -13107);
        chk("qp0_q5", int'($signed(bus.quantized[5])), 160);
        chk("qp0_q1", int'($signed(bus.quantized[1])), 246);
        check_levels("qp0");
        finish_block("qp0");

        // Backpressure: out_ready low, new in_valid ignored
        set_random_block();
        start_block("hold");
        wait_done("hold", 0, 18);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_q0", int'($signed(bus.quantized[0])), ref_level(blk[0], 0, qpb, qpm, intra_b));
        end
        check_levels("hold");
        bus.in_valid = 1'b0;
        finish_block("hold");

        // Enable low for 3 cycles at index 7
        set_random_block();
        start_block("pause");
        repeat (7) tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("pause_no_valid", int'(bus.out_valid), 0);
        enable = 1'b1;
        wait_done("pause", 10, 21);
        check_levels("pause");
        finish_block("pause");

        // Reset pulse mid-run
        set_random_block();
        start_block("mid_rst");
        repeat (9) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        nzq = 0;
        for (int i = 0; i < 16; i++) if (bus.quantized[i] != '0) nzq++;
        chk("mid_rst_quant_zero", nzq, 0);
        tick();
        reset = 1'b1;
        nzq = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid) nzq++;
        end
        chk("mid_rst_no_partial", nzq, 0);
        set_random_block();
        start_block("after_rst");
        wait_done("after_rst", 0, 18);
        check_levels("after_rst");
        finish_block("after_rst");

        // Random blocks, including out-of-range QP fields
        for (int b = 0; b < 8; b++) begin
            set_random_block();
            start_block($sformatf("rnd%0d", b));
            wait_done($sformatf("rnd%0d", b), 0, 18);
            check_levels($sformatf("rnd%0d", b));
            finish_block($sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
